// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and sizing helpers for the RSA modular-exponentiation engine
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        SQUARE,
        MULT,
        DONE
    } mod_exp_state_t;

    function automatic int key_width(input int bytes);
        return 8 * bytes;
    endfunction

    localparam int DEFAULT_KEY_BYTES = 4;
    localparam int DEFAULT_W         = key_width(DEFAULT_KEY_BYTES);
    // Cycles spent in each multiply state: start issue, W iterations, done cycle
    localparam int MULT_CYCLES       = DEFAULT_W + 2;

endpackage

// File: rtl/mod_exp_if.sv
// rtl/mod_exp_if.sv - operand/result bundle between the UART deserializer, mod_exp and the TX serializer
interface mod_exp_if
    import rsa_pkg::*;
#(
    parameter int MSG_BYTES = 2,
    parameter int KEY_BYTES = 4
);
    localparam int W = key_width(KEY_BYTES);

    logic                     valid_in;
    logic [8*MSG_BYTES-1:0]   message_in;
    logic [W-1:0]             exponent_in;
    logic [W-1:0]             modulus_in;
    logic                     busy_out;
    logic                     valid_out;
    logic [W-1:0]             result_out;
    logic                     error_out;

    modport master (
        output valid_in, message_in, exponent_in, modulus_in,
        input  busy_out, valid_out, result_out, error_out
    );

    modport slave (
        input  valid_in, message_in, exponent_in, modulus_in,
        output busy_out, valid_out, result_out, error_out
    );

endinterface

// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - interleaved shift-add modular multiplier, product = a*b mod n in W+1 cycles
module mod_mult #(
    parameter int W = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] n_in,
    output logic         done_out,
    output logic [W-1:0] product_out
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  n_r;
    logic [W-1:0]  p;
    logic [CW-1:0] j;
    logic          running;

    // Partial sum is at most 2(n-1) + (n-1) < 3n, so two subtractions restore p < n
    logic [W+1:0] sum;
    logic [W+1:0] sub1;
    logic [W+1:0] step;

    always_comb begin
        sum  = {1'b0, p, 1'b0} + (a_r[j] ? {2'b00, b_r} : {(W+2){1'b0}});
        sub1 = (sum  >= {2'b00, n_r}) ? sum  - {2'b00, n_r} : sum;
        step = (sub1 >= {2'b00, n_r}) ? sub1 - {2'b00, n_r} : sub1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_r      <= '0;
            b_r      <= '0;
            n_r      <= '0;
            p        <= '0;
            j        <= '0;
            running  <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start_in) begin
                a_r     <= a_in;
                b_r     <= b_in;
                n_r     <= n_in;
                p       <= '0;
                j       <= CW'(W - 1);
                running <= 1'b1;
            end else if (running) begin
                p <= step[W-1:0];
                if (j == '0) begin
                    running  <= 1'b0;
                    done_out <= 1'b1;
                end else begin
                    j <= j - 1'b1;
                end
            end
        end
    end

    assign product_out = p;

endmodule

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - constant-time left-to-right square-and-multiply engine: result = message^exponent mod modulus
module mod_exp
    import rsa_pkg::*;
#(
    parameter int MSG_BYTES = 2,
    parameter int KEY_BYTES = 4
) (
    input  logic      clk_in,
    input  logic      rst_in,
    mod_exp_if.slave  bus
);
    localparam int W  = key_width(KEY_BYTES);
    localparam int IW = $clog2(W);

    if (MSG_BYTES > KEY_BYTES) begin : g_bad_widths
        $error("mod_exp: MSG_BYTES must not exceed KEY_BYTES");
    end

    mod_exp_state_t state;
    logic [W-1:0]   msg_r;
    logic [W-1:0]   exp_r;
    logic [W-1:0]   mod_r;
    logic [W-1:0]   acc;
    logic [W-1:0]   base;
    logic [IW-1:0]  idx;
    logic           start;
    logic           err_pend;
    logic           busy;
    logic           valid_o;
    logic [W-1:0]   result;
    logic           error;

    logic           mult_done;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic [W-1:0]   mult_p;

    // Multiplier operands follow the state; the multiplier latches them one cycle after entry
    always_comb begin
        mult_a = acc;
        mult_b = acc;
        if (state == REDUCE) begin
            mult_a = msg_r;
            mult_b = W'(1);
        end else if (state == MULT) begin
            mult_b = base;
        end
    end

    mod_mult #(.W(W)) u_mult (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start),
        .a_in        (mult_a),
        .b_in        (mult_b),
        .n_in        (mod_r),
        .done_out    (mult_done),
        .product_out (mult_p)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            msg_r    <= '0;
            exp_r    <= '0;
            mod_r    <= '0;
            acc      <= '0;
            base     <= '0;
            idx      <= '0;
            start    <= 1'b0;
            err_pend <= 1'b0;
            busy     <= 1'b0;
            valid_o  <= 1'b0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            start   <= 1'b0;
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still high here means this is the valid_out cycle: not yet accepting
                    busy <= 1'b0;
                    if (bus.valid_in && !busy) begin
                        busy  <= 1'b1;
                        msg_r <= W'(bus.message_in);
                        exp_r <= bus.exponent_in;
                        mod_r <= bus.modulus_in;
                        idx   <= IW'(W - 1);
                        if (bus.modulus_in == '0) begin
                            acc      <= '0;
                            err_pend <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc      <= W'(1);
                            err_pend <= 1'b0;
                            start    <= 1'b1;
                            state    <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    if (mult_done) begin
                        base  <= mult_p;
                        acc   <= (mod_r == W'(1)) ? '0 : W'(1);
                        start <= 1'b1;
                        state <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (mult_done) begin
                        acc   <= mult_p;
                        start <= 1'b1;
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (mult_done) begin
                        if (exp_r[idx]) begin
                            acc <= mult_p;
                        end
                        if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            start <= 1'b1;
                            state <= SQUARE;
                        end
                    end
                end
                DONE: begin
                    result  <= acc;
                    error   <= err_pend;
                    valid_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out   = busy;
    assign bus.valid_out  = valid_o;
    assign bus.result_out = result;
    assign bus.error_out  = error;

endmodule
